// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-lite encodings used by the bus test vectors.
// Also holds small helpers common to the vector blocks.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    function automatic logic [15:0] sat_inc(
        input logic [15:0] v,
        input logic        en
    );
        return (en && v != 16'hffff) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/ahb3lite_svec_if.sv
// AHB3-lite slave-port signal bundle.
// The master side also observes the bus-wide HREADY.
interface ahb3lite_svec_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE,
        output HBURST, HPROT, HTRANS,
        input  HREADY, HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE,
        input  HBURST, HPROT, HTRANS, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb3lite_svec_lfsr.sv
// Fibonacci LFSR: shift right, new MSB is parity of tapped bits.
// Advances once per cycle that step is high.
module ahb3lite_svec_lfsr #(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] POLY = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (step) begin
            value <= {^(value & POLY), value[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ahb3lite_svec.sv
// AHB3-lite RAM slave with LFSR-driven wait states and
// two-cycle ERROR responses for illegal accesses.
module ahb3lite_svec
    import ahb3lite_pkg::*;
#(
    parameter logic [31:0] SLAVE_ADDR = 32'h0,
    parameter int unsigned SLAVE_SIZE = 1024,
    parameter logic [31:0] WAIT_SEED  = 32'hcafef00d,
    parameter logic [31:0] WAIT_POLY  = 32'h00200007,
    parameter int unsigned WAIT_MAX   = 3
) (
    input  logic           CLK,
    input  logic           RESETn,
    ahb3lite_svec_if.slave bus,
    output logic [15:0]    WR_COUNT,
    output logic [15:0]    RD_COUNT,
    output logic [15:0]    ERR_COUNT
);

    localparam int unsigned WORDS = SLAVE_SIZE / 4;
    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_DATA,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            act_q, act_d;
    logic            wr_q, wr_d;
    logic [3:0]      mask_q, mask_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [15:0]     wrc_q, wrc_d;
    logic [15:0]     rdc_q, rdc_d;
    logic [15:0]     errc_q, errc_d;

    logic [31:0]     mem [WORDS];
    logic [31:0]     lfsr_v;
    logic            lfsr_step;
    logic [31:0]     off;
    logic [AW-1:0]   idx;
    logic            accept;
    logic            illegal;
    logic            ready;
    logic            done;
    logic            commit;
    logic [3:0]      lanes;
    logic [31:0]     bmask;
    logic [31:0]     rword;
    logic [31:0]     fwd;
    logic [2:0]      wcnt;
    logic            unused;

    ahb3lite_svec_lfsr #(
        .WIDTH (32),
        .SEED  (WAIT_SEED),
        .POLY  (WAIT_POLY)
    ) u_lfsr (
        .clk   (CLK),
        .rst_n (RESETn),
        .step  (lfsr_step),
        .value (lfsr_v)
    );

    assign off    = bus.HADDR - SLAVE_ADDR;
    assign idx    = off[AW+1:2];
    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign ready  = (state_q == S_DATA) | (state_q == S_ERR2);
    assign done   = (state_q == S_DATA) & act_q;
    assign commit = done & wr_q;

    // Wrapped offset also catches addresses below the window.
    assign illegal = (off >= 32'(SLAVE_SIZE))
                   | (bus.HSIZE > HSIZE_WORD)
                   | ((bus.HSIZE == HSIZE_HALF) & bus.HADDR[0])
                   | ((bus.HSIZE == HSIZE_WORD) & (|bus.HADDR[1:0]));

    // Low bits of the post-step LFSR are the pre-step bits [3:1].
    assign wcnt = 3'(32'(lfsr_v[3:1]) % (WAIT_MAX + 1));

    always_comb begin
        lanes = 4'b0000;
        unique case (1'b1)
            bus.HSIZE == HSIZE_BYTE: lanes = 4'b0001 << bus.HADDR[1:0];
            bus.HSIZE == HSIZE_HALF: lanes = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            default:                 lanes = 4'b1111;
        endcase
    end

    always_comb begin
        bmask = '0;
        for (int b = 0; b < 4; b++) begin
            bmask[8*b +: 8] = {8{mask_q[b]}};
        end
    end

    assign rword = mem[idx];
    assign fwd   = (commit && idx == idx_q)
                 ? ((rword & ~bmask) | (bus.HWDATA & bmask))
                 : rword;

    always_ff @(posedge CLK) begin
        if (commit) begin
            mem[idx_q] <= (mem[idx_q] & ~bmask) | (bus.HWDATA & bmask);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        act_d     = act_q;
        wr_d      = wr_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        rdata_d   = rdata_q;
        lfsr_step = 1'b0;
        unique case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = S_DATA;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_DATA;
                act_d   = 1'b0;
                if (accept) begin
                    lfsr_step = 1'b1;
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else begin
                        act_d  = 1'b1;
                        wr_d   = bus.HWRITE;
                        mask_d = lanes;
                        idx_d  = idx;
                        if (!bus.HWRITE) rdata_d = fwd;
                        if (wcnt != 3'd0) begin
                            state_d = S_WAIT;
                            cnt_d   = wcnt;
                        end
                    end
                end
            end
        endcase
        wrc_d  = sat_inc(wrc_q, commit);
        rdc_d  = sat_inc(rdc_q, done & ~wr_q);
        errc_d = sat_inc(errc_q, ready & accept & illegal);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            act_q   <= 1'b0;
            wr_q    <= 1'b0;
            mask_q  <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            wrc_q   <= '0;
            rdc_q   <= '0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            wr_q    <= wr_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            wrc_q   <= wrc_d;
            rdc_q   <= rdc_d;
            errc_q  <= errc_d;
        end
    end

    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = ((state_q == S_ERR1) | (state_q == S_ERR2))
                         ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = rdata_q;
    assign WR_COUNT      = wrc_q;
    assign RD_COUNT      = rdc_q;
    assign ERR_COUNT     = errc_q;

    assign unused = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0],
                      lfsr_v[31:4], lfsr_v[0]};

endmodule

// File: tb/tb_ahb3lite_svec.sv
// Randomised bench for ahb3lite_svec against a byte-level RAM,
// LFSR and counter reference model.
module tb_ahb3lite_svec;
    import ahb3lite_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          SIZE = 1024;
    localparam logic [31:0] SEED = 32'hcafef00d;
    localparam logic [31:0] POLY = 32'h00200007;
    localparam int          WMAX = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] wr_cnt, rd_cnt, err_cnt;
    int          total = 0;
    int          bad   = 0;

    ahb3lite_svec_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    always #5 clk = ~clk;

    ahb3lite_svec #(
        .SLAVE_ADDR (BASE),
        .SLAVE_SIZE (SIZE),
        .WAIT_SEED  (SEED),
        .WAIT_POLY  (POLY),
        .WAIT_MAX   (WMAX)
    ) dut (
        .CLK       (clk),
        .RESETn    (rst_n),
        .bus       (bus),
        .WR_COUNT  (wr_cnt),
        .RD_COUNT  (rd_cnt),
        .ERR_COUNT (err_cnt)
    );

    logic [7:0]  mref [SIZE];
    logic [31:0] lfsr_m;
    int          wr_n, rd_n, err_n;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] adv(input logic [31:0] v);
        return {^(v & POLY), v[31:1]};
    endfunction

    function automatic int wait_of(input logic [31:0] v);
        return int'(v[2:0]) % (WMAX + 1);
    endfunction

    function automatic bit is_ill(input logic [31:0] a,
                                  input logic [2:0] sz);
        if (a < BASE || a >= BASE + 32'(SIZE)) return 1'b1;
        if (sz > 3'd2) return 1'b1;
        if (sz == 3'd1 && a[0]) return 1'b1;
        if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] a);
        int o;
        o = int'(a - BASE) & ~3;
        return {mref[o+3], mref[o+2], mref[o+1], mref[o]};
    endfunction

    task automatic maccept(input logic [31:0] a, input logic [2:0] sz,
                           output bit ill, output int ew);
        lfsr_m = adv(lfsr_m);
        ill    = is_ill(a, sz);
        ew     = ill ? 1 : wait_of(lfsr_m);
        if (ill) err_n++;
    endtask

    task automatic mcommit(input bit wr, input logic [31:0] a,
                           input logic [2:0] sz, input logic [31:0] wd);
        int o;
        o = int'(a - BASE);
        if (wr) begin
            for (int i = 0; i < (1 << sz); i++)
                mref[o+i] = wd[8*((o+i)%4) +: 8];
            wr_n++;
        end else begin
            rd_n++;
        end
    endtask

    task automatic addr(input bit wr, input logic [31:0] a,
                        input logic [2:0] sz);
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HADDR  = a;
        bus.HWRITE = wr;
        bus.HSIZE  = sz;
    endtask

    task automatic idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
    endtask

    task automatic dphase(input bit ill, input bit wr, input int ew,
                          input logic [31:0] er);
        int w;
        w = 0;
        @(negedge clk);
        while (bus.HREADYOUT !== 1'b1 && w < 16) begin
            w++;
            chk("resp_wait", 32'(bus.HRESP), 32'(ill));
            if (!ill && !wr) chk("rd_hold", bus.HRDATA, er);
            @(negedge clk);
        end
        chk("waits", w, ew);
        chk("resp", 32'(bus.HRESP), 32'(ill));
        if (!ill && !wr) chk("rdata", bus.HRDATA, er);
    endtask

    task automatic xfer(input bit wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd);
        bit          ill;
        int          ew;
        logic [31:0] er;
        addr(wr, a, sz);
        @(posedge clk); #1;
        idle();
        bus.HWDATA = wd;
        maccept(a, sz, ill, ew);
        er = ill ? 32'h0 : mword(a);
        dphase(ill, wr, ew, er);
        @(posedge clk); #1;
        if (!ill) mcommit(wr, a, sz, wd);
    endtask

    task automatic b2b(input logic [31:0] a, input logic [31:0] wd);
        bit          ill;
        int          ew;
        logic [31:0] er;
        addr(1'b1, a, HSIZE_WORD);
        @(posedge clk); #1;
        maccept(a, HSIZE_WORD, ill, ew);
        bus.HWDATA = wd;
        addr(1'b0, a, HSIZE_WORD);
        dphase(ill, 1'b1, ew, 32'h0);
        @(posedge clk); #1;
        mcommit(1'b1, a, HSIZE_WORD, wd);
        idle();
        maccept(a, HSIZE_WORD, ill, ew);
        er = mword(a);
        dphase(ill, 1'b0, ew, er);
        @(posedge clk); #1;
        mcommit(1'b0, a, HSIZE_WORD, 32'h0);
    endtask

    task automatic rst_vals(input string tag);
        chk({tag, "_rdy"}, 32'(bus.HREADYOUT), 32'd1);
        chk({tag, "_resp"}, 32'(bus.HRESP), 32'd0);
        chk({tag, "_rdata"}, bus.HRDATA, 32'h0);
        chk({tag, "_wrc"}, 32'(wr_cnt), 32'd0);
        chk({tag, "_rdc"}, 32'(rd_cnt), 32'd0);
        chk({tag, "_errc"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, old;
        logic [2:0]  sz;
        int          n;
        bus.HADDR  = '0;
        bus.HWDATA = '0;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = HSIZE_WORD;
        bus.HBURST = '0;
        bus.HPROT  = '0;
        idle();
        lfsr_m = SEED;
        wr_n = 0; rd_n = 0; err_n = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_vals("reset");
        rst_n = 1'b1;

        xfer(1'b1, BASE + 8, HSIZE_WORD, 32'h11223344);
        xfer(1'b0, BASE + 8, HSIZE_WORD, 32'h0);
        chk("word_rd", bus.HRDATA, 32'h11223344);
        chk("word_wrc", 32'(wr_cnt), 32'd1);
        chk("word_rdc", 32'(rd_cnt), 32'd1);

        xfer(1'b1, BASE + 16, HSIZE_WORD, 32'h0);
        xfer(1'b1, BASE + 17, HSIZE_BYTE, 32'h0000aa00);
        xfer(1'b1, BASE + 19, HSIZE_BYTE, 32'hbb000000);
        xfer(1'b0, BASE + 16, HSIZE_WORD, 32'h0);
        chk("byte_lanes", bus.HRDATA, 32'hbb00aa00);

        b2b(BASE + 4, 32'hdeadbeef);
        chk("fwd", bus.HRDATA, 32'hdeadbeef);

        xfer(1'b0, BASE + 32'(SIZE), HSIZE_WORD, 32'h0);
        xfer(1'b1, BASE + 18, HSIZE_WORD, 32'h55555555);
        xfer(1'b0, BASE + 16, HSIZE_WORD, 32'h0);
        chk("err_nomod", bus.HRDATA, 32'hbb00aa00);
        chk("err_cnt2", 32'(err_cnt), 32'd2);

        for (int i = 0; i < SIZE / 4; i++)
            xfer(1'b1, BASE + 32'(4*i), HSIZE_WORD, $urandom);
        for (int i = 0; i < SIZE / 4; i++)
            xfer(1'b0, BASE + 32'(4*i), HSIZE_WORD, 32'h0);

        for (int i = 0; i < 96; i++) begin
            sz = 3'($urandom_range(0, 3));
            a  = BASE + (32'($urandom_range(0, SIZE - 1))
                 & ~((32'd1 << sz) - 32'd1));
            if ($urandom_range(0, 9) == 0) a = a + 32'(SIZE);
            if ($urandom_range(0, 9) == 0) a = a | 32'd1;
            xfer(1'($urandom_range(0, 1)), a, sz, $urandom);
        end
        chk("wrc_model", 32'(wr_cnt), 32'(wr_n));
        chk("rdc_model", 32'(rd_cnt), 32'(rd_n));
        chk("errc_model", 32'(err_cnt), 32'(err_n));

        n = 0;
        while (wait_of(adv(lfsr_m)) == 0 && n < 50) begin
            xfer(1'b0, BASE, HSIZE_WORD, 32'h0);
            n++;
        end
        old = mword(BASE + 32);
        addr(1'b1, BASE + 32, HSIZE_WORD);
        @(posedge clk); #1;
        idle();
        bus.HWDATA = ~old;
        @(negedge clk);
        chk("rst_inwait", 32'(bus.HREADYOUT), 32'd0);
        rst_n = 1'b0;
        #1;
        rst_vals("midrst");
        lfsr_m = SEED;
        wr_n = 0; rd_n = 0; err_n = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(1'b0, BASE + 32, HSIZE_WORD, 32'h0);
        chk("rst_keep", bus.HRDATA, old);
        chk("rst_rdc", 32'(rd_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb3lite_svec.md
# ahb3lite_svec

AHB3-lite slave test vector: a word-organised RAM slave that inserts pseudo-random wait states from an LFSR and returns two-cycle ERROR responses for illegal accesses. It is the bus-end counterpart of the master vector generator. It sits on an AHB3-lite slave port, behind the decoder's HSEL, and exercises a master's wait-state, pipelining and error handling. Transfer and error counters are exported for the bench.

## Interface
- SLAVE_ADDR, 0: base byte address of the slave window.
- SLAVE_SIZE, 1024: window size in bytes; power of two, at least 4.
- WAIT_SEED, 32'hcafef00d: LFSR reset value; must be non-zero.
- WAIT_POLY, 32'h00200007: LFSR feedback taps.
- WAIT_MAX, 3: maximum wait states per transfer, 0..7; 0 disables wait insertion.
- CLK  input  1  bus clock; all state updates on its rising edge.
- RESETn  input  1  reset; asynchronous assert, active-low.
- HSEL  input  1  slave select.
- HADDR  input  32  address.
- HWDATA  input  32  write data (data phase).
- HWRITE  input  1  1 = write.
- HSIZE  input  3  transfer size; byte, half and word are legal.
- HBURST  input  3  ignored.
- HPROT  input  4  ignored.
- HTRANS  input  2  IDLE/BUSY/NONSEQ/SEQ.
- HREADY  input  1  bus-wide ready.
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.
- HRDATA  output  32  read data.
- WR_COUNT  output  16  completed OKAY writes.
- RD_COUNT  output  16  completed OKAY reads.
- ERR_COUNT  output  16  ERROR responses issued.

## Operation
- Accept: an address phase is accepted on a rising edge where HSEL & HREADY & HTRANS[1]. IDLE, BUSY and unselected cycles get a zero-wait OKAY.
- Accepted phase: capture address, size, write flag and lane mask. Step the LFSR once (Galois-free Fibonacci: shift right, MSB = ^(lfsr & WAIT_POLY)). Wait count = lfsr[2:0] modulo (WAIT_MAX+1).
- Illegal access, any of:
  - address outside [SLAVE_ADDR, SLAVE_ADDR+SLAVE_SIZE);
  - misaligned (half with HADDR[0]=1, word with HADDR[1:0]≠0);
  - HSIZE > word.
- Illegal accesses take no wait states and never modify memory.
- FSM states:
  - DATA: OKAY data phase, HREADYOUT=1. New address phases are accepted here.
  - WAIT: HREADYOUT=0, HRESP=0, count decrements; at zero go to DATA.
  - ERR1: HREADYOUT=0, HRESP=1; always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; then accept/DATA as normal.
- Writes commit at the edge ending the data phase with HREADYOUT=1. Lanes are little-endian from HADDR[1:0]/HSIZE.
- Reads: HRDATA is registered from memory at acceptance and is held stable through waits. If the read address hits a word being written in the completing data phase, the enabled HWDATA lanes are forwarded into HRDATA.
- Counters increment on OKAY completion (WR/RD) or on entering ERR1 (ERR), and saturate at 16'hffff.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, all counters 0, LFSR=WAIT_SEED, FSM=DATA. Memory contents are not reset.
- Reset mid-transfer: the transfer is abandoned and any pending write is dropped.

## Timing
- Zero-wait: address phase accepted at edge N; data phase spans N..N+1. Read data is valid and a write commits at edge N+1.
- With k waits: HREADYOUT is low for k cycles after edge N; completion is at edge N+1+k.
- Error: HREADYOUT low for exactly 1 cycle, high for 1, with HRESP=1 in both cycles.
- Back-to-back: the next address phase is accepted on the same edge that completes the current data phase. Sustained zero-wait throughput is 1 transfer per cycle.
- An address phase presented while HREADY=0 is ignored, and the master must hold it.

## Structure
- Shared package ahb3lite_pkg holds HTRANS_*, HSIZE_*, plus HRESP_OKAY/HRESP_ERROR (add these if absent). The FSM state typedef stays local.
- One natural sub-module: lfsr (parameters WIDTH, SEED, POLY; ports step, value). Other vector blocks reuse it.
- Lane-mask and forwarding logic stay inline.

## Test plan
- WAIT_MAX=0; word write 0x11223344 to SLAVE_ADDR+8, then read -> HRDATA=0x11223344 one cycle after acceptance; WR_COUNT=1, RD_COUNT=1.
- Byte writes 0xAA at +1 and 0xBB at +3 over a word of zero -> word read returns 0xBB00AA00.
- Back-to-back write of 0xDEADBEEF to +4 then immediate read of +4 -> forwarded 0xDEADBEEF with no extra cycle.
- Read at SLAVE_ADDR+SLAVE_SIZE, and a word at +2 -> each gives HREADYOUT 0 then 1 with HRESP=1 both cycles; memory is unchanged; ERR_COUNT=2.
- WAIT_MAX=3; 256 sequential writes then reads with the LFSR pattern -> every read matches; waits per transfer lie in 0..3 and follow the seeded LFSR sequence; HRDATA is stable during waits.
- Assert RESETn low during a WAIT cycle of a write -> outputs return to reset values immediately; the target word is unmodified on later read.
